// File: rtl/bram_port_arbiter_pkg.sv
// Shared defaults and types for the two-master BRAM port arbiter.
package bram_port_arbiter_pkg;

    localparam int BYTES_PER_WORD_DEF = 4;
    localparam int ADDRESS_WIDTH_DEF  = 32;
    localparam int MAX_LOCK_DEF       = 16;
    localparam int LOCK_CNT_W         = 8;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_idx_e;

    function automatic port_idx_e other_port(input port_idx_e p);
        return (p == PORT0) ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/rr_lock_arb2.sv
// Two-way round-robin arbiter with bounded lock ownership; grant is combinational
// from req/lock, the pointer/owner/counter update on the clock edge.
module rr_lock_arb2
    import bram_port_arbiter_pkg::*;
#(
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] grant,
    output logic       forced_release
);

    port_idx_e                 last_q, last_d;
    port_idx_e                 owner_q, owner_d;
    logic                      owner_vld_q, owner_vld_d;
    logic [LOCK_CNT_W-1:0]     lock_cnt_q, lock_cnt_d;

    logic                      owner_active;
    port_idx_e                 gidx;
    logic [LOCK_CNT_W-1:0]     cnt_n;

    // Pointer resets to port 1 so the first conflict goes to port 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_q      <= PORT1;
            owner_q     <= PORT0;
            owner_vld_q <= 1'b0;
            lock_cnt_q  <= '0;
        end else begin
            last_q      <= last_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            lock_cnt_q  <= lock_cnt_d;
        end
    end

    always_comb begin
        last_d         = last_q;
        owner_d        = owner_q;
        owner_vld_d    = owner_active;
        lock_cnt_d     = owner_active ? lock_cnt_q : '0;
        forced_release = 1'b0;
        cnt_n          = '0;
        if (|grant) begin
            last_d = gidx;
            if (lock[gidx]) begin
                cnt_n = (owner_active && (owner_q == gidx)) ? lock_cnt_q + 1'b1
                                                            : LOCK_CNT_W'(1);
                if (cnt_n >= LOCK_CNT_W'(MAX_LOCK)) begin
                    owner_vld_d    = 1'b0;
                    lock_cnt_d     = '0;
                    forced_release = 1'b1;
                end else begin
                    owner_vld_d = 1'b1;
                    owner_d     = gidx;
                    lock_cnt_d  = cnt_n;
                end
            end else begin
                owner_vld_d = 1'b0;
                lock_cnt_d  = '0;
            end
        end
    end

    always_comb begin
        owner_active = owner_vld_q & req[owner_q] & lock[owner_q];
        grant        = req;
        gidx         = PORT0;
        if (req == 2'b11) begin
            gidx  = owner_active ? owner_q : other_port(last_q);
            grant = (gidx == PORT1) ? 2'b10 : 2'b01;
        end else if (req[1]) begin
            gidx = PORT1;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-cycle BRAM port between two masters; grant is same-cycle,
// completion (rvalid/rdata) follows one cycle later, losers simply hold their request.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF,
    parameter int ADDRESS_WIDTH  = ADDRESS_WIDTH_DEF,
    parameter int MAX_LOCK       = MAX_LOCK_DEF
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        m0_req,
    input  logic                        m0_lock,
    input  logic [ADDRESS_WIDTH-1:0]    m0_addr,
    input  logic [BYTES_PER_WORD-1:0]   m0_we,
    input  logic [BYTES_PER_WORD*8-1:0] m0_wdata,
    output logic                        m0_gnt,
    output logic                        m0_rvalid,
    output logic [BYTES_PER_WORD*8-1:0] m0_rdata,
    input  logic                        m1_req,
    input  logic                        m1_lock,
    input  logic [ADDRESS_WIDTH-1:0]    m1_addr,
    input  logic [BYTES_PER_WORD-1:0]   m1_we,
    input  logic [BYTES_PER_WORD*8-1:0] m1_wdata,
    output logic                        m1_gnt,
    output logic                        m1_rvalid,
    output logic [BYTES_PER_WORD*8-1:0] m1_rdata,
    output logic                        bram_clk,
    output logic                        bram_rst,
    output logic [ADDRESS_WIDTH-1:0]    bram_addr,
    output logic                        bram_en,
    output logic [BYTES_PER_WORD-1:0]   bram_we,
    output logic [BYTES_PER_WORD*8-1:0] bram_din,
    input  logic [BYTES_PER_WORD*8-1:0] bram_dout,
    output logic [7:0]                  status
);

    logic [1:0] req_v;
    logic [1:0] grant;
    logic       forced_release;
    logic       withdrawn;

    logic [1:0] rvalid_q;
    logic [1:0] pend_q;
    logic [1:0] status_q, status_d;

    assign req_v = {m1_req, m0_req} & {2{~RST}};

    rr_lock_arb2 #(
        .MAX_LOCK(MAX_LOCK)
    ) u_arb (
        .CLK           (CLK),
        .RST           (RST),
        .req           (req_v),
        .lock          ({m1_lock, m0_lock}),
        .grant         (grant),
        .forced_release(forced_release)
    );

    assign m0_gnt   = grant[0];
    assign m1_gnt   = grant[1];
    assign bram_clk = CLK;
    assign bram_rst = RST;
    assign bram_en  = |grant;

    always_comb begin
        bram_addr = '0;
        bram_we   = '0;
        bram_din  = '0;
        if (grant[0]) begin
            bram_addr = m0_addr;
            bram_we   = m0_we;
            bram_din  = m0_wdata;
        end else if (grant[1]) begin
            bram_addr = m1_addr;
            bram_we   = m1_we;
            bram_din  = m1_wdata;
        end
    end

    // A request left ungranted last cycle must still be present now.
    assign withdrawn = |(pend_q & ~req_v);
    assign status_d  = status_q | {withdrawn, forced_release};

    always_ff @(posedge CLK) begin
        if (RST) begin
            rvalid_q <= '0;
            pend_q   <= '0;
            status_q <= '0;
        end else begin
            rvalid_q <= grant;
            pend_q   <= req_v & ~grant;
            status_q <= status_d;
        end
    end

    // Masking with RST drops a completion that was in flight when reset hit.
    assign m0_rvalid = rvalid_q[0] & ~RST;
    assign m1_rvalid = rvalid_q[1] & ~RST;
    assign m0_rdata  = m0_rvalid ? bram_dout : '0;
    assign m1_rdata  = m1_rvalid ? bram_dout : '0;
    assign status    = RST ? 8'h00 : {6'b0, status_q};

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a small behavioural BRAM (MAX_LOCK=4).
module tb_bram_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        m0_req, m0_lock, m1_req, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_we, m1_we;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bram_clk, bram_rst, bram_en;
    logic [31:0] bram_addr, bram_din, bram_dout;
    logic [3:0]  bram_we;
    logic [7:0]  status;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [16];

    always #5 CLK = ~CLK;

    bram_port_arbiter #(
        .BYTES_PER_WORD(4),
        .ADDRESS_WIDTH (32),
        .MAX_LOCK      (4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .m0_req   (m0_req),
        .m0_lock  (m0_lock),
        .m0_addr  (m0_addr),
        .m0_we    (m0_we),
        .m0_wdata (m0_wdata),
        .m0_gnt   (m0_gnt),
        .m0_rvalid(m0_rvalid),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_lock  (m1_lock),
        .m1_addr  (m1_addr),
        .m1_we    (m1_we),
        .m1_wdata (m1_wdata),
        .m1_gnt   (m1_gnt),
        .m1_rvalid(m1_rvalid),
        .m1_rdata (m1_rdata),
        .bram_clk (bram_clk),
        .bram_rst (bram_rst),
        .bram_addr(bram_addr),
        .bram_en  (bram_en),
        .bram_we  (bram_we),
        .bram_din (bram_din),
        .bram_dout(bram_dout),
        .status   (status)
    );

    // Behavioural BRAM: one-cycle read, byte-strobed write; reset preloads word k with 0x11223340+k.
    always @(posedge bram_clk) begin
        if (bram_rst) begin
            for (int k = 0; k < 16; k++) mem[k] <= 32'h1122_3340 + 32'(k);
            bram_dout <= '0;
        end else if (bram_en) begin
            bram_dout <= mem[bram_addr[5:2]];
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) mem[bram_addr[5:2]][b*8 +: 8] <= bram_din[b*8 +: 8];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_lock = 0; m0_addr = '0; m0_we = '0; m0_wdata = '0;
        m1_req = 0; m1_lock = 0; m1_addr = '0; m1_we = '0; m1_wdata = '0;
    endtask

    initial begin
        idle();
        m0_req  = 1;
        m0_addr = 32'h10;
        tick();
        @(negedge CLK);
        check_eq("rst_gnt0",   {31'b0, m0_gnt},    0);
        check_eq("rst_en",     {31'b0, bram_en},   0);
        check_eq("rst_we",     {28'b0, bram_we},   0);
        check_eq("rst_rvalid", {31'b0, m0_rvalid}, 0);
        check_eq("rst_status", {24'b0, status},    0);
        check_eq("rst_bramrst",{31'b0, bram_rst},  1);

        tick(); RST = 0; idle();
        @(negedge CLK);
        check_eq("post_rst_en",     {31'b0, bram_en},   0);
        check_eq("post_rst_rvalid", {31'b0, m0_rvalid}, 0);

        // Single read by m0 from 0x10
        tick(); m0_req = 1; m0_addr = 32'h10;
        @(negedge CLK);
        check_eq("rd_m0_gnt",  {31'b0, m0_gnt},  1);
        check_eq("rd_m1_gnt",  {31'b0, m1_gnt},  0);
        check_eq("rd_en",      {31'b0, bram_en}, 1);
        check_eq("rd_addr",    bram_addr,        32'h10);
        check_eq("rd_we",      {28'b0, bram_we}, 0);
        tick(); idle();
        @(negedge CLK);
        check_eq("rd_rvalid",  {31'b0, m0_rvalid}, 1);
        check_eq("rd_rdata",   m0_rdata,           32'h1122_3344);
        check_eq("rd_m1_rv",   {31'b0, m1_rvalid}, 0);
        check_eq("idle_en",    {31'b0, bram_en},   0);
        check_eq("idle_addr",  bram_addr,          0);

        // m0 writes, m1 reads the same word back
        tick(); m0_req = 1; m0_addr = 32'h20; m0_we = 4'hF; m0_wdata = 32'hDEAD_BEEF;
        @(negedge CLK);
        check_eq("wr_gnt",  {31'b0, m0_gnt},  1);
        check_eq("wr_addr", bram_addr,        32'h20);
        check_eq("wr_we",   {28'b0, bram_we}, 32'hF);
        check_eq("wr_din",  bram_din,         32'hDEAD_BEEF);
        tick(); idle(); m1_req = 1; m1_addr = 32'h20;
        @(negedge CLK);
        check_eq("rb_m1_gnt", {31'b0, m1_gnt},    1);
        check_eq("wr_rvalid", {31'b0, m0_rvalid}, 1);
        check_eq("rb_we",     {28'b0, bram_we},   0);
        tick(); idle();
        @(negedge CLK);
        check_eq("rb_rvalid", {31'b0, m1_rvalid}, 1);
        check_eq("rb_rdata",  m1_rdata,           32'hDEAD_BEEF);
        check_eq("rb_m0_rv",  {31'b0, m0_rvalid}, 0);

        // m1 locks; m0 joins one cycle later and wins only after 4 locked grants
        for (int i = 0; i < 5; i++) begin
            tick();
            m1_req = 1; m1_lock = 1; m1_addr = 32'h24;
            m0_req = (i > 0); m0_addr = 32'h28;
            @(negedge CLK);
            check_eq($sformatf("lock_m1_gnt%0d", i), {31'b0, m1_gnt},    {31'b0, i < 4});
            check_eq($sformatf("lock_m0_gnt%0d", i), {31'b0, m0_gnt},    {31'b0, i == 4});
            check_eq($sformatf("lock_st0_%0d", i),   {31'b0, status[0]}, {31'b0, i == 4});
        end
        tick(); idle();
        @(negedge CLK);
        check_eq("lock_m0_rv",  {31'b0, m0_rvalid}, 1);
        check_eq("status_lock", {24'b0, status},    32'h01);
        tick();
        @(negedge CLK);
        check_eq("status_wdrw", {24'b0, status},    32'h03);

        // Reset lands the cycle after a grant: the completion is dropped
        tick(); m1_req = 1; m1_addr = 32'h10;
        @(negedge CLK);
        check_eq("pre_rst_gnt", {31'b0, m1_gnt}, 1);
        tick(); RST = 1; idle();
        @(negedge CLK);
        check_eq("rst2_rvalid", {31'b0, m1_rvalid}, 0);
        check_eq("rst2_en",     {31'b0, bram_en},   0);
        check_eq("rst2_status", {24'b0, status},    0);
        tick(); RST = 0;
        @(negedge CLK);
        check_eq("rst2_rv_after", {31'b0, m1_rvalid}, 0);
        check_eq("rst2_status_q", {24'b0, status},    0);

        // Both request continuously: m0 first, then strict alternation
        for (int i = 0; i < 6; i++) begin
            tick();
            m0_req = 1; m0_addr = 32'h30;
            m1_req = 1; m1_addr = 32'h34;
            @(negedge CLK);
            check_eq($sformatf("rr_m0_gnt%0d", i), {31'b0, m0_gnt}, {31'b0, (i % 2) == 0});
            check_eq($sformatf("rr_m1_gnt%0d", i), {31'b0, m1_gnt}, {31'b0, (i % 2) == 1});
            if (i > 0) begin
                check_eq($sformatf("rr_m0_rv%0d", i), {31'b0, m0_rvalid}, {31'b0, (i % 2) == 1});
                check_eq($sformatf("rr_m1_rv%0d", i), {31'b0, m1_rvalid}, {31'b0, (i % 2) == 0});
            end
        end
        tick(); idle();
        @(negedge CLK);
        check_eq("rr_last_m1_rv", {31'b0, m1_rvalid}, 1);
        check_eq("rr_last_m0_rv", {31'b0, m0_rvalid}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
